mux_arbiter: RTL and testbench

Round-robin arbiter that shares one mux-selected resource (register-file write port, memory bus, ALU operand path) among `N_REQ` requesters. It tracks which requester owns the resource and drives the `i_sel` input of the downstream `mux`. It holds ownership until the owner signals completion or withdraws, and forcibly reclaims the resource after a programmable hold limit. It sits between requester control logic and the shared `mux`.

---
 rtl/mux_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin owner tracker for a shared mux-selected resource.
// A grant is held until the owner finishes or withdraws, or until the
// hold watchdog reclaims it. A release re-arbitrates on the same edge, so
// back-to-back owners see no idle cycle between grants.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// BUSY  | one requester owns the resource, hold counter running
module mux_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic                       i_done,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [$clog2(N_REQ)-1:0]   o_sel,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int SW = $clog2(N_REQ);
  // A disabled watchdog still gets a 1-bit counter so the vector is legal.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit WD_EN = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0] PTR_RST   = SW'(N_REQ - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic            any_req;
  logic            hi_found, lo_found;
  logic [SW-1:0]   hi_idx, lo_idx, win_idx;
  logic            owner_req;
  logic            release_own;
  logic            do_grant;

  // Winner search: first request above the last owner, else first from index 0.
  // Only indices below N_REQ are scanned, so unused encodings never win.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_req[i]) begin
        if (i > int'(ptr_q)) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = SW'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = SW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    any_req = |i_req;
  end

  // Next-state: release priority is done, then withdrawal, then watchdog.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    release_own = 1'b0;
    do_grant    = 1'b0;
    owner_req   = |(i_req & gnt_q);

    case (state_q)
      IDLE: begin
        do_grant = any_req;
      end
      BUSY: begin
        if (i_done) begin
          release_own = 1'b1;
        end else if (!owner_req) begin
          release_own = 1'b1;
        end else if (WD_EN && (cnt_q == HOLD_LAST)) begin
          release_own = 1'b1;
          timeout_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        do_grant = release_own && any_req;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_grant) begin
      state_d = BUSY;
      gnt_d   = N_REQ'(1) << win_idx;
      sel_d   = win_idx;
      ptr_d   = win_idx;
      cnt_d   = '0;
    end else if (release_own) begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and output registers; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_sel     = sel_q;
  assign o_busy    = (state_q == BUSY);
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a 2-requester instance with a short
// watchdog and a 4-requester instance for round-robin ordering.
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;

  logic [1:0] req2;
  logic       done2;
  logic [1:0] gnt2;
  logic [0:0] sel2;
  logic       busy2, to2;

  logic [3:0] req4;
  logic       done4;
  logic [3:0] gnt4;
  logic [1:0] sel4;
  logic       busy4, to4;

  int n_cmp = 0;
  int n_err = 0;

  mux_arbiter #(.N_REQ(2), .MAX_HOLD(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_done(done2),
    .o_gnt(gnt2), .o_sel(sel2), .o_busy(busy2), .o_timeout(to2)
  );

  mux_arbiter #(.N_REQ(4), .MAX_HOLD(8)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req4), .i_done(done4),
    .o_gnt(gnt4), .o_sel(sel4), .o_busy(busy4), .o_timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner 4-way: pulse done on one edge and check the next owner appears without a bubble.
  task automatic rr_step(input logic [1:0] exp_sel, input string tag);
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
    chk({tag, "_sel"}, 32'(sel4), 32'(exp_sel));
    chk({tag, "_gnt"}, 32'(gnt4), 32'(4'b0001 << exp_sel));
    chk({tag, "_busy"}, 32'(busy4), 32'd1);
    tick();
    chk({tag, "_hold"}, 32'(sel4), 32'(exp_sel));
    chk({tag, "_hold_busy"}, 32'(busy4), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    req2 = '0; done2 = 1'b0;
    req4 = '0; done4 = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_gnt2", 32'(gnt2), 32'd0);
    chk("rst_sel2", 32'(sel2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_to2", 32'(to2), 32'd0);
    chk("rst_gnt4", 32'(gnt4), 32'd0);
    chk("rst_sel4", 32'(sel4), 32'd0);
    rst_n = 1'b1;

    // Single request, then done with request dropped.
    req2 = 2'b01;
    tick();
    chk("single_gnt", 32'(gnt2), 32'b01);
    chk("single_sel", 32'(sel2), 32'd0);
    chk("single_busy", 32'(busy2), 32'd1);
    tick();
    chk("single_hold", 32'(gnt2), 32'b01);
    req2 = 2'b00; done2 = 1'b1;
    tick();
    done2 = 1'b0;
    chk("done_gnt", 32'(gnt2), 32'd0);
    chk("done_busy", 32'(busy2), 32'd0);
    chk("done_sel", 32'(sel2), 32'd0);

    // done while idle has no effect.
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    chk("idle_done_busy", 32'(busy2), 32'd0);
    chk("idle_done_gnt", 32'(gnt2), 32'd0);

    // Owner 1 withdraws while requester 0 asks.
    req2 = 2'b10;
    tick();
    chk("wd1_gnt", 32'(gnt2), 32'b10);
    chk("wd1_sel", 32'(sel2), 32'd1);
    req2 = 2'b01;
    tick();
    chk("withdraw_sel", 32'(sel2), 32'd0);
    chk("withdraw_gnt", 32'(gnt2), 32'b01);
    chk("withdraw_to", 32'(to2), 32'd0);
    chk("withdraw_busy", 32'(busy2), 32'd1);

    // Owner 0 withdraws, 1 granted, then 1 withdraws to idle; sel holds last owner.
    req2 = 2'b10;
    tick();
    chk("hop_sel", 32'(sel2), 32'd1);
    req2 = 2'b00;
    tick();
    chk("idle_gnt", 32'(gnt2), 32'd0);
    chk("idle_busy", 32'(busy2), 32'd0);
    chk("idle_sel_keep", 32'(sel2), 32'd1);
    tick();
    chk("idle_sel_keep2", 32'(sel2), 32'd1);

    // Watchdog: 4-cycle hold, reclaim, immediate regrant of requester 0.
    req2 = 2'b01;
    tick();
    chk("wdog_g0", 32'(gnt2), 32'b01);
    chk("wdog_t0", 32'(to2), 32'd0);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("wdog_hold_gnt", 32'(gnt2), 32'b01);
      chk("wdog_hold_to", 32'(to2), 32'd0);
    end
    tick();
    chk("wdog_pulse", 32'(to2), 32'd1);
    chk("wdog_regrant", 32'(gnt2), 32'b01);
    chk("wdog_busy", 32'(busy2), 32'd1);
    tick();
    chk("wdog_pulse_end", 32'(to2), 32'd0);
    tick();
    tick();
    chk("wdog_pre_limit", 32'(to2), 32'd0);
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    chk("wdog_done_to", 32'(to2), 32'd0);
    chk("wdog_done_gnt", 32'(gnt2), 32'b01);
    tick();
    chk("wdog_done_to2", 32'(to2), 32'd0);

    // Async reset mid-grant with owner 1.
    req2 = 2'b10;
    tick();
    chk("pre_rst_sel", 32'(sel2), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt2), 32'd0);
    chk("arst_busy", 32'(busy2), 32'd0);
    chk("arst_sel", 32'(sel2), 32'd0);
    chk("arst_to", 32'(to2), 32'd0);
    req2 = 2'b11;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt2), 32'b01);
    chk("post_rst_sel", 32'(sel2), 32'd0);
    req2 = 2'b00;

    // Round-robin on the 4-way instance.
    req4 = 4'b1111;
    tick();
    chk("rr0_sel", 32'(sel4), 32'd0);
    chk("rr0_gnt", 32'(gnt4), 32'b0001);
    tick();
    rr_step(2'd1, "rr1");
    rr_step(2'd2, "rr2");
    rr_step(2'd3, "rr3");
    rr_step(2'd0, "rr4");
    rr_step(2'd1, "rr5");
    rr_step(2'd2, "rr6");
    rr_step(2'd3, "rr7");
    chk("rr_no_to", 32'(to4), 32'd0);

    // Wrap and skip from owner 3.
    req4 = 4'b0100;
    done4 = 1'b1;
    tick();
    chk("skip_sel", 32'(sel4), 32'd2);
    chk("skip_gnt", 32'(gnt4), 32'b0100);
    req4 = 4'b1001;
    tick();
    chk("wrap_sel", 32'(sel4), 32'd3);
    chk("wrap_gnt", 32'(gnt4), 32'b1000);
    req4 = 4'b0000;
    tick();
    done4 = 1'b0;
    chk("rr_idle_gnt", 32'(gnt4), 32'd0);
    chk("rr_idle_busy", 32'(busy4), 32'd0);
    chk("rr_idle_sel", 32'(sel4), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
